// File: rtl/cpu_consts_pkg.sv
// Shared execute-stage constants: divider FSM states and M-extension function encodings.
package cpu_consts;

  typedef enum logic [1:0] {
    S_DIV_IDLE,
    S_DIV_RUN,
    S_DIV_FIX,
    S_DIV_DONE
  } div_state_t;

  // funct3-style encodings shared by the multiply and divide units
  localparam logic [3:0] FUNC_MUL    = 4'd0;
  localparam logic [3:0] FUNC_MULH   = 4'd1;
  localparam logic [3:0] FUNC_MULHSU = 4'd2;
  localparam logic [3:0] FUNC_MULHU  = 4'd3;
  localparam logic [3:0] FUNC_DIV    = 4'd4;
  localparam logic [3:0] FUNC_DIVU   = 4'd5;
  localparam logic [3:0] FUNC_REM    = 4'd6;
  localparam logic [3:0] FUNC_REMU   = 4'd7;

endpackage

// File: rtl/divide_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            fits;

  // One extra bit above the partial remainder makes the borrow the compare result.
  assign shifted  = {rem, quo[XLEN-1]};
  assign diff     = shifted - {2'b00, divisor};
  assign fits     = ~diff[XLEN+1];
  assign rem_next = fits ? diff[XLEN:0] : shifted[XLEN:0];
  assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/divide.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W forms), one quotient bit per cycle.
module divide
  import cpu_consts::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic            div_valid_i,
  input  logic [3:0]      div_func_i,
  input  logic            word_op_i,
  output logic            div_ready_o,
  input  logic            flush_i,
  input  logic            div_res_ready_i,
  output logic [XLEN-1:0] div_res_o,
  output logic            div_res_valid_o
);

  localparam int HALF = XLEN / 2;

  function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  div_state_t      state;
  logic [6:0]      cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q, divisor_q, res_q;
  logic            sign_q, sign_r, is_rem_q, word_q;

  logic [3:0]      func_n;
  logic            is_signed, is_rem, a_neg, b_neg, b_zero, ovf, special, accept;
  logic [XLEN-1:0] a_raw, a_ext, b_ext, abs_a, abs_b, min_val, special_res;
  logic [XLEN-1:0] q_val, r_val, pick, fix_res, quo_next;
  logic [XLEN:0]   rem_next;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    func_n = div_func_i;
    if (!(div_func_i inside {FUNC_DIV, FUNC_DIVU, FUNC_REM, FUNC_REMU})) func_n = FUNC_DIVU;
    is_signed = (func_n == FUNC_DIV) || (func_n == FUNC_REM);
    is_rem    = (func_n == FUNC_REM) || (func_n == FUNC_REMU);

    // a_raw is the dividend at op width as the architecture returns it
    a_raw = word_op_i ? sext_w(opr_a_i[HALF-1:0]) : opr_a_i;
    a_ext = (word_op_i && !is_signed) ? {{HALF{1'b0}}, opr_a_i[HALF-1:0]} : a_raw;
    b_ext = opr_b_i;
    if (word_op_i)
      b_ext = is_signed ? sext_w(opr_b_i[HALF-1:0]) : {{HALF{1'b0}}, opr_b_i[HALF-1:0]};

    a_neg = is_signed & a_ext[XLEN-1];
    b_neg = is_signed & b_ext[XLEN-1];
    abs_a = a_neg ? -a_ext : a_ext;
    abs_b = b_neg ? -b_ext : b_ext;

    min_val = word_op_i ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    ovf     = is_signed && (a_ext == min_val) && (b_ext == '1);
    special = b_zero | ovf;
    if (b_zero) special_res = is_rem ? a_raw : '1;
    else        special_res = is_rem ? '0 : a_raw;
  end

  always_comb begin
    q_val   = sign_q ? -quo_q : quo_q;
    r_val   = sign_r ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    pick    = is_rem_q ? r_val : q_val;
    fix_res = word_q ? sext_w(pick[HALF-1:0]) : pick;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign div_ready_o     = (state == S_DIV_IDLE);
  assign accept          = div_valid_i & div_ready_o & ~flush_i;
  assign div_res_valid_o = (state == S_DIV_DONE) & ~flush_i;
  assign div_res_o       = div_res_valid_o ? res_q : '0;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_DIV_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      res_q     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      is_rem_q  <= 1'b0;
      word_q    <= 1'b0;
    end else begin
      case (state)
        S_DIV_IDLE: if (accept) begin
          sign_q    <= a_neg ^ b_neg;
          sign_r    <= a_neg;
          is_rem_q  <= is_rem;
          word_q    <= word_op_i;
          divisor_q <= abs_b;
          rem_q     <= '0;
          // W dividends sit in the upper half so 32 shifts consume them
          quo_q     <= word_op_i ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
          cnt       <= word_op_i ? 7'(HALF - 1) : 7'(XLEN - 1);
          if (special) begin
            res_q <= special_res;
            state <= S_DIV_DONE;
          end else begin
            state <= S_DIV_RUN;
          end
        end
        S_DIV_RUN: begin
          if (flush_i) begin
            state <= S_DIV_IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt - 7'd1;
            if (cnt == 7'd0) state <= S_DIV_FIX;
          end
        end
        S_DIV_FIX: begin
          if (flush_i) begin
            state <= S_DIV_IDLE;
          end else begin
            res_q <= fix_res;
            state <= S_DIV_DONE;
          end
        end
        S_DIV_DONE: if (flush_i || div_res_ready_i) state <= S_DIV_IDLE;
        default: state <= S_DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: directed and random ops through a scoreboard, plus handshake cases.
module tb_divide;
  import cpu_consts::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] opr_a_i = '0, opr_b_i = '0;
  logic        div_valid_i = 1'b0;
  logic [3:0]  div_func_i = '0;
  logic        word_op_i = 1'b0;
  logic        div_ready_o;
  logic        flush_i = 1'b0;
  logic        div_res_ready_i = 1'b0;
  logic [63:0] div_res_o;
  logic        div_res_valid_o;

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  divide dut (
    .clk             (clk),
    .reset           (reset),
    .opr_a_i         (opr_a_i),
    .opr_b_i         (opr_b_i),
    .div_valid_i     (div_valid_i),
    .div_func_i      (div_func_i),
    .word_op_i       (word_op_i),
    .div_ready_o     (div_ready_o),
    .flush_i         (flush_i),
    .div_res_ready_i (div_res_ready_i),
    .div_res_o       (div_res_o),
    .div_res_valid_o (div_res_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference built on native SV division, independent of the iterative datapath.
  function automatic void model(input logic [3:0] f, input logic w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res, output int lat);
    logic [3:0]  ff;
    logic        sg, rm, ovf;
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    ff  = (f inside {FUNC_DIV, FUNC_DIVU, FUNC_REM, FUNC_REMU}) ? f : FUNC_DIVU;
    sg  = (ff == FUNC_DIV) || (ff == FUNC_REM);
    rm  = (ff == FUNC_REM) || (ff == FUNC_REMU);
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      ovf = sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF;
      if (b32 == 0)  begin q32 = '1;  r32 = a32; end
      else if (ovf)  begin q32 = a32; r32 = '0;  end
      else if (sg)   begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else           begin q32 = a32 / b32; r32 = a32 % b32; end
      res = rm ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
      lat = (b32 == 0 || ovf) ? 1 : 34;
    end else begin
      ovf = sg && a == 64'h8000_0000_0000_0000 && b == '1;
      if (b == 0)    begin q = '1; r = a;  end
      else if (ovf)  begin q = a;  r = '0; end
      else if (sg)   begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else           begin q = a / b; r = a % b; end
      res = rm ? r : q;
      lat = (b == 0 || ovf) ? 1 : 66;
    end
  endfunction

  // Drives one request at a negedge; returns at the negedge of cycle 1 after the accept edge.
  task automatic start(input logic [3:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    int g = 0;
    @(negedge clk);
    while (!div_ready_o && g < 200) begin @(negedge clk); g++; end
    div_func_i  = f;
    word_op_i   = w;
    opr_a_i     = a;
    opr_b_i     = b;
    div_valid_i = 1'b1;
    @(negedge clk);
    div_valid_i = 1'b0;
  endtask

  task automatic collect();
    exp_t e;
    int   cyc = 1;
    e = sb.pop_front();
    while (!div_res_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
    check({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
    check(e.tag, div_res_o, e.res);
    div_res_ready_i = 1'b1;
    @(negedge clk);
    div_res_ready_i = 1'b0;
    check({e.tag, "_released"}, {62'd0, div_ready_o, div_res_valid_o}, 64'b10);
  endtask

  task automatic run_op(input string tag, input logic [3:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    sb.push_back('{tag, exp, lat});
    start(f, w, a, b);
    collect();
  endtask

  task automatic run_rand(input string tag, input logic [3:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp;
    int          lat;
    model(f, w, a, b, exp, lat);
    run_op(tag, f, w, a, b, exp, lat);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (div_res_valid_o) seen++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    int          stable;
    logic [3:0]  funcs [6];
    logic [63:0] ra, rb;
    funcs = '{FUNC_DIV, FUNC_DIVU, FUNC_REM, FUNC_REMU, FUNC_MUL, 4'hF};

    repeat (3) @(negedge clk);
    check("reset_state", {div_ready_o, div_res_valid_o, div_res_o}, {1'b1, 1'b0, 64'd0});
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", {div_ready_o, div_res_valid_o, div_res_o}, {1'b1, 1'b0, 64'd0});

    run_op("div_neg7_2",  FUNC_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("rem_neg7_2",  FUNC_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("divu_max_16", FUNC_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66);
    run_op("remu_max_16", FUNC_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 66);
    run_op("div_by_zero", FUNC_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_by_zero", FUNC_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf", FUNC_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", FUNC_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run_op("divw_ovf", FUNC_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_neg7_3", FUNC_REM, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("divuw_max_2", FUNC_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34);
    run_op("illegal_as_divu", 4'hF, 1'b0, -64'sd7, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 66);

    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i == 5) rb = '0;
      run_rand($sformatf("rand%0d", i), funcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), ra, rb);
    end

    // flush while the iteration is running
    start(FUNC_DIV, 1'b0, 64'd100, 64'd7);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_run_idle", {62'd0, div_ready_o, div_res_valid_o}, 64'b10);
    count_valid(80, seen);
    check("flush_run_no_result", 64'(seen), 64'd0);

    // flush in idle blocks the accept
    @(negedge clk);
    div_func_i = FUNC_DIV; word_op_i = 1'b0; opr_a_i = 64'd100; opr_b_i = 64'd7;
    div_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    div_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_blocks", {63'd0, div_ready_o}, 64'd1);
    count_valid(70, seen);
    check("flush_idle_no_result", 64'(seen), 64'd0);

    // flush together with res_ready in DONE masks valid at once
    start(FUNC_DIV, 1'b0, 64'd5, 64'd0);
    check("done_valid", {63'd0, div_res_valid_o}, 64'd1);
    flush_i = 1'b1; div_res_ready_i = 1'b1;
    #1;
    check("flush_done_masked", {div_res_valid_o, div_res_o}, 65'd0);
    @(negedge clk);
    flush_i = 1'b0; div_res_ready_i = 1'b0;
    check("flush_done_idle", {62'd0, div_ready_o, div_res_valid_o}, 64'b10);

    // consumer stalls for 5 cycles: result must hold and transfer once
    start(FUNC_REMU, 1'b0, 64'd5, 64'd0);
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (div_res_valid_o && div_res_o == 64'd5 && !div_ready_o) stable++;
      @(negedge clk);
    end
    check("stall_stable", 64'(stable), 64'd5);
    div_res_ready_i = 1'b1;
    @(negedge clk);
    div_res_ready_i = 1'b0;
    count_valid(5, seen);
    check("stall_one_transfer", 64'(seen), 64'd0);

    // async reset mid-op
    start(FUNC_DIV, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_midop", {div_ready_o, div_res_valid_o, div_res_o}, {1'b1, 1'b0, 64'd0});
    @(negedge clk);
    reset = 1'b0;
    count_valid(80, seen);
    check("reset_no_result", 64'(seen), 64'd0);

    // unit still works after the abort
    run_op("after_reset", FUNC_DIVU, 1'b0, 64'd1000, 64'd3, 64'd333, 66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
